mem_port_arbiter: RTL and testbench

- Shares one single-port, fixed-latency instruction/data memory between the IF stage (instruction fetch) and the MEM stage (load/store) of the 5-stage ARM pipeline.
- Grants one access at a time. Sequences the memory command and latency count, and returns data with a one-cycle ready pulse.
- Produces per-stage freeze signals that stall the pipeline while a request is pending.
- Data accesses have priority. A starvation counter guarantees forward progress for fetch.

---
 rtl/mem_port_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates one fixed-latency single-port memory between instruction fetch and load/store.
// Data accesses win unless fetch has been starved for STARVE_LIMIT consecutive data grants.
module mem_port_arbiter #(
  parameter int unsigned WORD_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned MEM_LATENCY  = 2,
  parameter int unsigned STARVE_LIMIT = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  // Instruction fetch port
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic [WORD_WIDTH-1:0] if_rdata,
  output logic                  if_ready,
  output logic                  freeze_if,
  // Load/store port
  input  logic                  mem_rd_req,
  input  logic                  mem_wr_req,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [WORD_WIDTH-1:0] mem_wdata,
  output logic [WORD_WIDTH-1:0] mem_rdata,
  output logic                  mem_ready,
  output logic                  freeze_mem,
  // Memory command port
  output logic                  sram_en,
  output logic                  sram_we,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [WORD_WIDTH-1:0] sram_wdata,
  input  logic [WORD_WIDTH-1:0] sram_rdata,
  output logic                  busy
);

  localparam int unsigned LatW    = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam int unsigned StarveW = $clog2(STARVE_LIMIT + 1);

  localparam logic [LatW-1:0]    LatInit   = LatW'(MEM_LATENCY - 1);
  localparam logic [StarveW-1:0] StarveMax = StarveW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StResp
  } state_e;

  typedef enum logic {
    OwnIf,
    OwnData
  } owner_e;

  state_e                state_q, state_d;
  owner_e                owner_q, owner_d;
  logic [LatW-1:0]       lat_q, lat_d;
  logic [StarveW-1:0]    starve_q, starve_d;

  logic                  sram_en_q, sram_en_d;
  logic                  sram_we_q, sram_we_d;
  logic [ADDR_WIDTH-1:0] sram_addr_q, sram_addr_d;
  logic [WORD_WIDTH-1:0] sram_wdata_q, sram_wdata_d;
  logic [WORD_WIDTH-1:0] if_rdata_q, if_rdata_d;
  logic [WORD_WIDTH-1:0] mem_rdata_q, mem_rdata_d;
  logic                  if_ready_q, if_ready_d;
  logic                  mem_ready_q, mem_ready_d;
  logic                  busy_q, busy_d;

  logic data_req;
  logic grant_if;
  logic grant_data;

  // A simultaneous read and write request is treated as a write.
  assign data_req   = mem_rd_req | mem_wr_req;
  assign grant_if   = if_req & (~data_req | (starve_q == StarveMax));
  assign grant_data = data_req & ~grant_if;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    lat_d        = lat_q;
    starve_d     = starve_q;
    sram_en_d    = sram_en_q;
    sram_we_d    = sram_we_q;
    sram_addr_d  = sram_addr_q;
    sram_wdata_d = sram_wdata_q;
    if_rdata_d   = if_rdata_q;
    mem_rdata_d  = mem_rdata_q;
    if_ready_d   = 1'b0;
    mem_ready_d  = 1'b0;

    case (state_q)
      StIdle: begin
        if (grant_if) begin
          owner_d     = OwnIf;
          sram_addr_d = if_addr;
          sram_we_d   = 1'b0;
          starve_d    = '0;
        end else if (grant_data) begin
          owner_d      = OwnData;
          sram_addr_d  = mem_addr;
          sram_we_d    = mem_wr_req;
          sram_wdata_d = mem_wdata;
          if (if_req && (starve_q != StarveMax)) begin
            starve_d = starve_q + StarveW'(1);
          end
        end
        if (grant_if || grant_data) begin
          sram_en_d = 1'b1;
          lat_d     = LatInit;
          state_d   = StBusy;
        end
      end

      StBusy: begin
        if (lat_q != '0) begin
          lat_d = lat_q - LatW'(1);
        end else begin
          // Last latency cycle: read data is valid now.
          if (!sram_we_q) begin
            if (owner_q == OwnIf) begin
              if_rdata_d = sram_rdata;
            end else begin
              mem_rdata_d = sram_rdata;
            end
          end
          sram_en_d   = 1'b0;
          sram_we_d   = 1'b0;
          if_ready_d  = (owner_q == OwnIf);
          mem_ready_d = (owner_q == OwnData);
          state_d     = StResp;
        end
      end

      StResp: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      owner_q      <= OwnIf;
      lat_q        <= '0;
      starve_q     <= '0;
      sram_en_q    <= 1'b0;
      sram_we_q    <= 1'b0;
      sram_addr_q  <= '0;
      sram_wdata_q <= '0;
      if_rdata_q   <= '0;
      mem_rdata_q  <= '0;
      if_ready_q   <= 1'b0;
      mem_ready_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      lat_q        <= lat_d;
      starve_q     <= starve_d;
      sram_en_q    <= sram_en_d;
      sram_we_q    <= sram_we_d;
      sram_addr_q  <= sram_addr_d;
      sram_wdata_q <= sram_wdata_d;
      if_rdata_q   <= if_rdata_d;
      mem_rdata_q  <= mem_rdata_d;
      if_ready_q   <= if_ready_d;
      mem_ready_q  <= mem_ready_d;
      busy_q       <= busy_d;
    end
  end

  assign sram_en    = sram_en_q;
  assign sram_we    = sram_we_q;
  assign sram_addr  = sram_addr_q;
  assign sram_wdata = sram_wdata_q;
  assign if_rdata   = if_rdata_q;
  assign mem_rdata  = mem_rdata_q;
  assign if_ready   = if_ready_q;
  assign mem_ready  = mem_ready_q;
  assign busy       = busy_q;

  assign freeze_if  = ~rst & if_req & ~if_ready_q;
  assign freeze_mem = ~rst & data_req & ~mem_ready_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: two instances (latency 2/limit 2 and latency 1/limit 1)
// share stimulus and are checked cycle by cycle against a transaction-timeline model.
module tb_mem_port_arbiter;

  localparam int unsigned WW = 32;
  localparam int unsigned AW = 32;
  localparam int unsigned NumCycles = 4000;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req, mem_rd_req, mem_wr_req;
  logic [AW-1:0] if_addr, mem_addr;
  logic [WW-1:0] mem_wdata;

  logic [WW-1:0] sram_rdata [2];
  logic [WW-1:0] if_rdata   [2];
  logic [WW-1:0] mem_rdata  [2];
  logic [WW-1:0] sram_wdata [2];
  logic [AW-1:0] sram_addr  [2];
  logic          if_ready   [2];
  logic          mem_ready  [2];
  logic          freeze_if  [2];
  logic          freeze_mem [2];
  logic          sram_en    [2];
  logic          sram_we    [2];
  logic          busy       [2];

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .WORD_WIDTH  (WW),
    .ADDR_WIDTH  (AW),
    .MEM_LATENCY (2),
    .STARVE_LIMIT(2)
  ) u_dut0 (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata[0]),
    .if_ready  (if_ready[0]),
    .freeze_if (freeze_if[0]),
    .mem_rd_req(mem_rd_req),
    .mem_wr_req(mem_wr_req),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata[0]),
    .mem_ready (mem_ready[0]),
    .freeze_mem(freeze_mem[0]),
    .sram_en   (sram_en[0]),
    .sram_we   (sram_we[0]),
    .sram_addr (sram_addr[0]),
    .sram_wdata(sram_wdata[0]),
    .sram_rdata(sram_rdata[0]),
    .busy      (busy[0])
  );

  mem_port_arbiter #(
    .WORD_WIDTH  (WW),
    .ADDR_WIDTH  (AW),
    .MEM_LATENCY (1),
    .STARVE_LIMIT(1)
  ) u_dut1 (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata[1]),
    .if_ready  (if_ready[1]),
    .freeze_if (freeze_if[1]),
    .mem_rd_req(mem_rd_req),
    .mem_wr_req(mem_wr_req),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata[1]),
    .mem_ready (mem_ready[1]),
    .freeze_mem(freeze_mem[1]),
    .sram_en   (sram_en[1]),
    .sram_we   (sram_we[1]),
    .sram_addr (sram_addr[1]),
    .sram_wdata(sram_wdata[1]),
    .sram_rdata(sram_rdata[1]),
    .busy      (busy[1])
  );

  // Reference model: one outstanding transaction per instance, placed on a cycle timeline.
  int            lat   [2] = '{2, 1};
  int            limit [2] = '{2, 1};
  bit            m_active [2];
  int            m_start  [2];
  bit            m_own_if [2];
  logic [AW-1:0] m_addr   [2];
  bit            m_we     [2];
  logic [WW-1:0] m_wdata  [2];
  logic [WW-1:0] m_if_rd  [2];
  logic [WW-1:0] m_mem_rd [2];
  int            m_starve [2];

  int cyc;
  int n_cmp;
  int n_err;
  bit prev_if_ready;
  bit prev_mem_ready;

  function automatic logic [WW-1:0] mem_word(input logic [AW-1:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hE3A0_0001;
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic bit exp_busy_phase(input int k);
    int off;
    off = cyc - m_start[k];
    return m_active[k] && (off >= 1) && (off <= lat[k]);
  endfunction

  function automatic bit exp_resp_phase(input int k);
    return m_active[k] && ((cyc - m_start[k]) == lat[k] + 1);
  endfunction

  task automatic model_reset(input int k);
    m_active[k] = 1'b0;
    m_start[k]  = 0;
    m_own_if[k] = 1'b0;
    m_addr[k]   = '0;
    m_we[k]     = 1'b0;
    m_wdata[k]  = '0;
    m_if_rd[k]  = '0;
    m_mem_rd[k] = '0;
    m_starve[k] = 0;
  endtask

  task automatic drive_inputs();
    rst = ($urandom_range(0, 59) == 0);
    if (!if_req || prev_if_ready) begin
      if_req = ($urandom_range(0, 2) != 0);
    end else if ($urandom_range(0, 31) == 0) begin
      if_req = 1'b0;
    end
    if (!(mem_rd_req || mem_wr_req) || prev_mem_ready) begin
      mem_rd_req = 1'b0;
      mem_wr_req = 1'b0;
      if ($urandom_range(0, 2) != 0) begin
        case ($urandom_range(0, 3))
          0, 1:    mem_rd_req = 1'b1;
          2:       mem_wr_req = 1'b1;
          default: begin
            mem_rd_req = 1'b1;
            mem_wr_req = 1'b1;
          end
        endcase
      end
    end else if ($urandom_range(0, 31) == 0) begin
      mem_rd_req = 1'b0;
      mem_wr_req = 1'b0;
    end
    // Addresses and data wander every cycle; only the grant-cycle values may be used.
    if_addr   = $urandom;
    mem_addr  = $urandom;
    mem_wdata = $urandom;
    for (int k = 0; k < 2; k++) begin
      if (m_active[k] && (cyc - m_start[k] == lat[k])) sram_rdata[k] = mem_word(m_addr[k]);
      else sram_rdata[k] = $urandom;
    end
  endtask

  task automatic check_dut(input int k);
    bit b, r, ir, mr;
    string p;
    p  = $sformatf("d%0d_", k);
    b  = exp_busy_phase(k);
    r  = exp_resp_phase(k);
    ir = r && m_own_if[k];
    mr = r && !m_own_if[k];
    check_eq({p, "sram_en"}, 64'(sram_en[k]), 64'(b));
    check_eq({p, "sram_we"}, 64'(sram_we[k]), 64'(b && m_we[k]));
    check_eq({p, "busy"}, 64'(busy[k]), 64'(b || r));
    if (b) check_eq({p, "sram_addr"}, 64'(sram_addr[k]), 64'(m_addr[k]));
    if (b && m_we[k]) check_eq({p, "sram_wdata"}, 64'(sram_wdata[k]), 64'(m_wdata[k]));
    check_eq({p, "if_ready"}, 64'(if_ready[k]), 64'(ir));
    check_eq({p, "mem_ready"}, 64'(mem_ready[k]), 64'(mr));
    check_eq({p, "if_rdata"}, 64'(if_rdata[k]), 64'(m_if_rd[k]));
    check_eq({p, "mem_rdata"}, 64'(mem_rdata[k]), 64'(m_mem_rd[k]));
    check_eq({p, "freeze_if"}, 64'(freeze_if[k]), 64'(!rst && if_req && !ir));
    check_eq({p, "freeze_mem"}, 64'(freeze_mem[k]),
             64'(!rst && (mem_rd_req || mem_wr_req) && !mr));
  endtask

  task automatic model_step(input int k);
    bit data, g_if;
    if (rst) begin
      model_reset(k);
      return;
    end
    if (m_active[k]) begin
      if ((cyc - m_start[k] == lat[k]) && !m_we[k]) begin
        if (m_own_if[k]) m_if_rd[k] = mem_word(m_addr[k]);
        else m_mem_rd[k] = mem_word(m_addr[k]);
      end
      if (cyc - m_start[k] == lat[k] + 1) m_active[k] = 1'b0;
    end else begin
      data = mem_rd_req || mem_wr_req;
      g_if = if_req && (!data || m_starve[k] == limit[k]);
      if (g_if || data) begin
        m_active[k] = 1'b1;
        m_start[k]  = cyc;
        m_own_if[k] = g_if;
        m_addr[k]   = g_if ? if_addr : mem_addr;
        m_we[k]     = !g_if && mem_wr_req;
        if (!g_if) m_wdata[k] = mem_wdata;
        if (g_if) m_starve[k] = 0;
        else if (if_req && m_starve[k] < limit[k]) m_starve[k]++;
      end
    end
  endtask

  initial begin
    n_cmp          = 0;
    n_err          = 0;
    cyc            = 0;
    prev_if_ready  = 1'b0;
    prev_mem_ready = 1'b0;
    rst            = 1'b1;
    if_req         = 1'b0;
    mem_rd_req     = 1'b0;
    mem_wr_req     = 1'b0;
    if_addr        = '0;
    mem_addr       = '0;
    mem_wdata      = '0;
    sram_rdata[0]  = '0;
    sram_rdata[1]  = '0;
    for (int k = 0; k < 2; k++) model_reset(k);
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      check_eq($sformatf("d%0d_reset_sram_addr", k), 64'(sram_addr[k]), 64'd0);
      check_eq($sformatf("d%0d_reset_sram_wdata", k), 64'(sram_wdata[k]), 64'd0);
      check_eq($sformatf("d%0d_reset_freeze_if", k), 64'(freeze_if[k]), 64'd0);
    end

    for (int i = 0; i < int'(NumCycles); i++) begin
      drive_inputs();
      #1;
      check_dut(0);
      check_dut(1);
      prev_if_ready  = exp_resp_phase(0) && m_own_if[0];
      prev_mem_ready = exp_resp_phase(0) && !m_own_if[0];
      model_step(0);
      model_step(1);
      cyc++;
      @(posedge clk);
      #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
